atm_txn_ctrl: RTL and testbench

Parametrised transaction controller for the ATM datapath, the successor to the single-bit `atm_fsm`. It compares the entered PIN against the card's stored PIN and allows a fixed number of retries before retaining the card. It checks the requested amount against the account balance and writes back the decremented balance. It drives a multi-cycle cash dispense, and cancel and inactivity-timeout paths eject the card. It sits between the keypad/card-reader front end and the account-store interface.

---
 rtl/atm_pkg.sv | 19 +
 rtl/atm_idle_timer.sv | 38 +++
 rtl/atm_txn_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and parameter limits for the ATM transaction controller.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIN_WAIT = 3'd1,
    AMT_WAIT = 3'd2,
    CHECK    = 3'd3,
    DISPENSE = 3'd4,
    EJECT    = 3'd5,
    RETAIN   = 3'd6
  } atm_state_e;

  localparam int MAX_TRIES_MIN    = 1;
  localparam int MAX_TRIES_MAX    = 15;
  localparam int TIMEOUT_CYC_MIN  = 2;
  localparam int DISPENSE_CYC_MIN = 1;

endpackage

// File: rtl/atm_idle_timer.sv
// Inactivity counter: counts while run is high, fires on its last count.
module atm_idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Holds at the last count so a late consumer still sees expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM transaction FSM: PIN check with retry limit, balance check and
// write-back, timed cash dispense, and card eject/retain handling.
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_W        = 16,
  parameter int AMT_W        = 16,
  parameter int MAX_TRIES    = 3,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int DISPENSE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_in,
  input  logic             cancel,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_entry,
  input  logic [PIN_W-1:0] stored_pin,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amt_req,
  input  logic [AMT_W-1:0] balance,
  output logic             dispense_cash,
  output logic [AMT_W-1:0] dispense_amt,
  output logic             balance_wr,
  output logic [AMT_W-1:0] new_balance,
  output logic             pin_err,
  output logic             insuff_funds,
  output logic             card_eject,
  output logic             card_retain,
  output logic [3:0]       tries_left,
  output logic [2:0]       state_o
);

  if (MAX_TRIES < MAX_TRIES_MIN || MAX_TRIES > MAX_TRIES_MAX ||
      TIMEOUT_CYC < TIMEOUT_CYC_MIN || DISPENSE_CYC < DISPENSE_CYC_MIN) begin : g_param_check
    $error("atm_txn_ctrl: parameter out of range");
  end

  localparam int DISP_W = $clog2(DISPENSE_CYC + 1);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISPENSE_CYC - 1);

  function automatic logic [3:0] sat_dec(input logic [3:0] val);
    return (val == 4'd0) ? 4'd0 : val - 4'd1;
  endfunction

  atm_state_e       state_q, state_d;
  logic             card_in_q;
  logic [3:0]       tries_q, tries_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-1:0] dispense_amt_q, dispense_amt_d;
  logic [AMT_W-1:0] new_balance_q, new_balance_d;
  logic             dispense_cash_q, dispense_cash_d;
  logic             balance_wr_q, balance_wr_d;
  logic             pin_err_q, pin_err_d;
  logic             insuff_q, insuff_d;
  logic             eject_q, eject_d;
  logic             retain_q, retain_d;
  logic             card_rise, amt_ok;
  logic             tmr_clear, tmr_run, tmr_expired;

  assign card_rise = card_in && !card_in_q;
  assign amt_ok    = (amt_q != '0) && (amt_q <= balance);
  assign tmr_run   = (state_q == PIN_WAIT) || (state_q == AMT_WAIT);

  atm_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .run    (tmr_run),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    tries_d       = tries_q;
    disp_d        = disp_q;
    amt_d         = amt_q;
    new_balance_d = new_balance_q;
    balance_wr_d  = 1'b0;
    pin_err_d     = 1'b0;
    insuff_d      = 1'b0;
    tmr_clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (card_rise) begin
          state_d   = PIN_WAIT;
          tries_d   = 4'(MAX_TRIES);
          tmr_clear = 1'b1;
        end
      end
      PIN_WAIT: begin
        if (!card_in) begin
          state_d = IDLE;
        end else if (cancel) begin
          state_d = EJECT;
        end else if (pin_valid) begin
          if (pin_entry == stored_pin) begin
            state_d   = AMT_WAIT;
            tmr_clear = 1'b1;
          end else begin
            pin_err_d = 1'b1;
            tries_d   = sat_dec(tries_q);
            if (tries_d == 4'd0) begin
              state_d = RETAIN;
            end else begin
              tmr_clear = 1'b1;
            end
          end
        end else if (tmr_expired) begin
          state_d = EJECT;
        end
      end
      AMT_WAIT: begin
        if (!card_in) begin
          state_d = IDLE;
        end else if (cancel) begin
          state_d = EJECT;
        end else if (amt_valid) begin
          amt_d   = amt_req;
          state_d = CHECK;
        end else if (tmr_expired) begin
          state_d = EJECT;
        end
      end
      CHECK: begin
        if (!card_in) begin
          state_d = IDLE;
        end else if (amt_ok) begin
          state_d       = DISPENSE;
          disp_d        = '0;
          balance_wr_d  = 1'b1;
          new_balance_d = balance - amt_q;
        end else begin
          insuff_d  = 1'b1;
          state_d   = AMT_WAIT;
          tmr_clear = 1'b1;
        end
      end
      DISPENSE: begin
        // Debit already committed: cancel and card removal are ignored here.
        if (disp_q == DISP_LAST) begin
          state_d = EJECT;
        end else begin
          disp_d = disp_q + DISP_W'(1);
        end
      end
      EJECT, RETAIN: begin
        if (!card_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dispense_cash_d = (state_d == DISPENSE);
    dispense_amt_d  = dispense_cash_d ? amt_q : '0;
    eject_d         = (state_d == EJECT);
    retain_d        = (state_d == RETAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      card_in_q       <= 1'b0;
      tries_q         <= 4'd0;
      disp_q          <= '0;
      dispense_amt_q  <= '0;
      new_balance_q   <= '0;
      dispense_cash_q <= 1'b0;
      balance_wr_q    <= 1'b0;
      pin_err_q       <= 1'b0;
      insuff_q        <= 1'b0;
      eject_q         <= 1'b0;
      retain_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      card_in_q       <= card_in;
      tries_q         <= tries_d;
      disp_q          <= disp_d;
      dispense_amt_q  <= dispense_amt_d;
      new_balance_q   <= new_balance_d;
      dispense_cash_q <= dispense_cash_d;
      balance_wr_q    <= balance_wr_d;
      pin_err_q       <= pin_err_d;
      insuff_q        <= insuff_d;
      eject_q         <= eject_d;
      retain_q        <= retain_d;
    end
  end

  always_ff @(posedge clk) begin
    amt_q <= amt_d;
  end

  assign dispense_cash = dispense_cash_q;
  assign dispense_amt  = dispense_amt_q;
  assign balance_wr    = balance_wr_q;
  assign new_balance   = new_balance_q;
  assign pin_err       = pin_err_q;
  assign insuff_funds  = insuff_q;
  assign card_eject    = eject_q;
  assign card_retain   = retain_q;
  assign tries_left    = tries_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Directed bench for atm_txn_ctrl with TIMEOUT_CYC=20, other parameters default.
module tb_atm_txn_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_in, cancel, pin_valid, amt_valid;
  logic [15:0] pin_entry, stored_pin, amt_req, balance;
  logic        dispense_cash, balance_wr, pin_err, insuff_funds, card_eject, card_retain;
  logic [15:0] dispense_amt, new_balance;
  logic [3:0]  tries_left;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  atm_txn_ctrl #(
    .PIN_W(16), .AMT_W(16), .MAX_TRIES(3), .TIMEOUT_CYC(20), .DISPENSE_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .cancel(cancel),
    .pin_valid(pin_valid), .pin_entry(pin_entry), .stored_pin(stored_pin),
    .amt_valid(amt_valid), .amt_req(amt_req), .balance(balance),
    .dispense_cash(dispense_cash), .dispense_amt(dispense_amt),
    .balance_wr(balance_wr), .new_balance(new_balance), .pin_err(pin_err),
    .insuff_funds(insuff_funds), .card_eject(card_eject), .card_retain(card_retain),
    .tries_left(tries_left), .state_o(state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_pin(input logic [15:0] pin);
    pin_valid = 1'b1;
    pin_entry = pin;
    step();
    pin_valid = 1'b0;
  endtask

  task automatic enter_amt(input logic [15:0] amt);
    amt_valid = 1'b1;
    amt_req   = amt;
    step();
    amt_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({dispense_cash, balance_wr, pin_err, insuff_funds, card_eject, card_retain} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
        {dispense_cash, balance_wr, pin_err, insuff_funds, card_eject, card_retain});
    end
    n_checks++;
    if (dispense_amt !== 16'd0 || new_balance !== 16'd0 || tries_left !== 4'd0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_values: got amt=%0d nb=%0d tries=%0d state=%0d expected all 0",
        dispense_amt, new_balance, tries_left, state_o);
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (state_o !== 3'd0) begin
      n_fail++; $display("FAIL reset_release_idle: got %0d expected 0", state_o);
    end
  endtask

  task automatic test_withdraw();
    card_in = 1'b1;
    step();
    n_checks++;
    if (state_o !== 3'd1 || tries_left !== 4'd3) begin
      n_fail++; $display("FAIL wd_insert: got state=%0d tries=%0d expected 1/3", state_o, tries_left);
    end
    enter_pin(16'h1234);
    n_checks++;
    if (state_o !== 3'd2) begin
      n_fail++; $display("FAIL wd_pin_ok: got state %0d expected 2", state_o);
    end
    enter_amt(16'd200);
    n_checks++;
    if (state_o !== 3'd3 || balance_wr !== 1'b0 || dispense_cash !== 1'b0) begin
      n_fail++; $display("FAIL wd_check: got state=%0d wr=%0d cash=%0d expected 3/0/0",
        state_o, balance_wr, dispense_cash);
    end
    step();
    n_checks++;
    if (state_o !== 3'd4 || balance_wr !== 1'b1 || new_balance !== 16'd300 ||
        dispense_cash !== 1'b1 || dispense_amt !== 16'd200) begin
      n_fail++; $display("FAIL wd_dispense_start: got state=%0d wr=%0d nb=%0d cash=%0d amt=%0d expected 4/1/300/1/200",
        state_o, balance_wr, new_balance, dispense_cash, dispense_amt);
    end
    for (int i = 0; i < 3; i++) begin
      card_in = (i != 1);
      cancel  = (i == 2);
      step();
      n_checks++;
      if (dispense_cash !== 1'b1 || balance_wr !== 1'b0 || state_o !== 3'd4) begin
        n_fail++; $display("FAIL wd_dispense_hold%0d: got cash=%0d wr=%0d state=%0d expected 1/0/4",
          i, dispense_cash, balance_wr, state_o);
      end
    end
    card_in = 1'b1;
    cancel  = 1'b0;
    step();
    n_checks++;
    if (dispense_cash !== 1'b0 || card_eject !== 1'b1 || state_o !== 3'd5) begin
      n_fail++; $display("FAIL wd_eject: got cash=%0d eject=%0d state=%0d expected 0/1/5",
        dispense_cash, card_eject, state_o);
    end
    card_in = 1'b0;
    step();
    n_checks++;
    if (state_o !== 3'd0 || card_eject !== 1'b0) begin
      n_fail++; $display("FAIL wd_remove: got state=%0d eject=%0d expected 0/0", state_o, card_eject);
    end
  endtask

  task automatic test_lockout();
    logic [3:0] exp_tries;
    card_in = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      exp_tries = 4'(3 - k);
      enter_pin(16'h1111);
      n_checks++;
      if (pin_err !== 1'b1 || tries_left !== exp_tries || balance_wr !== 1'b0) begin
        n_fail++; $display("FAIL lock_try%0d: got err=%0d tries=%0d wr=%0d expected 1/%0d/0",
          k, pin_err, tries_left, balance_wr, exp_tries);
      end
      n_checks++;
      if (card_retain !== (k == 3) || state_o !== ((k == 3) ? 3'd6 : 3'd1)) begin
        n_fail++; $display("FAIL lock_state%0d: got retain=%0d state=%0d expected %0d/%0d",
          k, card_retain, state_o, (k == 3), (k == 3) ? 6 : 1);
      end
      step();
      n_checks++;
      if (pin_err !== 1'b0 || balance_wr !== 1'b0) begin
        n_fail++; $display("FAIL lock_pulse%0d: got err=%0d wr=%0d expected 0/0", k, pin_err, balance_wr);
      end
    end
    card_in = 1'b0;
    step();
    n_checks++;
    if (state_o !== 3'd0 || card_retain !== 1'b0) begin
      n_fail++; $display("FAIL lock_remove: got state=%0d retain=%0d expected 0/0", state_o, card_retain);
    end
  endtask

  task automatic test_rejected();
    logic [15:0] amts [2];
    amts[0] = 16'd600;
    amts[1] = 16'd0;
    card_in = 1'b1;
    step();
    enter_pin(16'h1234);
    for (int k = 0; k < 2; k++) begin
      enter_amt(amts[k]);
      step();
      n_checks++;
      if (insuff_funds !== 1'b1 || state_o !== 3'd2 || balance_wr !== 1'b0) begin
        n_fail++; $display("FAIL rej_amt%0d: got insuff=%0d state=%0d wr=%0d expected 1/2/0",
          amts[k], insuff_funds, state_o, balance_wr);
      end
      step();
      n_checks++;
      if (insuff_funds !== 1'b0) begin
        n_fail++; $display("FAIL rej_pulse%0d: got %0d expected 0", amts[k], insuff_funds);
      end
    end
    enter_amt(16'd100);
    step();
    n_checks++;
    if (balance_wr !== 1'b1 || new_balance !== 16'd400 || insuff_funds !== 1'b0) begin
      n_fail++; $display("FAIL rej_accept: got wr=%0d nb=%0d insuff=%0d expected 1/400/0",
        balance_wr, new_balance, insuff_funds);
    end
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (card_eject !== 1'b1) begin
      n_fail++; $display("FAIL rej_eject: got %0d expected 1", card_eject);
    end
    card_in = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    card_in = 1'b1;
    step();
    for (int i = 1; i <= 19; i++) begin
      step();
      n_checks++;
      if (card_eject !== 1'b0 || state_o !== 3'd1) begin
        n_fail++; $display("FAIL to_wait%0d: got eject=%0d state=%0d expected 0/1", i, card_eject, state_o);
      end
    end
    step();
    n_checks++;
    if (card_eject !== 1'b1 || state_o !== 3'd5) begin
      n_fail++; $display("FAIL to_fire: got eject=%0d state=%0d expected 1/5", card_eject, state_o);
    end
    card_in = 1'b0;
    step();
  endtask

  task automatic test_same_cycle();
    card_in = 1'b1;
    step();
    cancel = 1'b1;
    enter_pin(16'h1234);
    cancel = 1'b0;
    n_checks++;
    if (state_o !== 3'd5 || card_eject !== 1'b1) begin
      n_fail++; $display("FAIL same_cancel: got state=%0d eject=%0d expected 5/1", state_o, card_eject);
    end
    card_in = 1'b0;
    step();
    card_in = 1'b1;
    step();
    enter_pin(16'h1234);
    card_in = 1'b0;
    step();
    n_checks++;
    if (state_o !== 3'd0 || card_eject !== 1'b0 || balance_wr !== 1'b0 || dispense_cash !== 1'b0) begin
      n_fail++; $display("FAIL same_drop: got state=%0d eject=%0d wr=%0d cash=%0d expected 0/0/0/0",
        state_o, card_eject, balance_wr, dispense_cash);
    end
  endtask

  task automatic test_reset_mid_dispense();
    card_in = 1'b1;
    step();
    enter_pin(16'h1234);
    enter_amt(16'd200);
    step();
    step();
    n_checks++;
    if (state_o !== 3'd4 || dispense_cash !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: got state=%0d cash=%0d expected 4/1", state_o, dispense_cash);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dispense_cash, balance_wr, pin_err, insuff_funds, card_eject, card_retain} !== 6'b0 ||
        dispense_amt !== 16'd0 || new_balance !== 16'd0 || tries_left !== 4'd0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL rst_async: got cash=%0d amt=%0d nb=%0d tries=%0d state=%0d expected all 0",
        dispense_cash, dispense_amt, new_balance, tries_left, state_o);
    end
    card_in = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (balance_wr !== 1'b0 || state_o !== 3'd0 || dispense_cash !== 1'b0) begin
        n_fail++; $display("FAIL rst_after%0d: got wr=%0d state=%0d cash=%0d expected 0/0/0",
          i, balance_wr, state_o, dispense_cash);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    card_in    = 1'b0;
    cancel     = 1'b0;
    pin_valid  = 1'b0;
    amt_valid  = 1'b0;
    pin_entry  = 16'h0;
    amt_req    = 16'h0;
    stored_pin = 16'h1234;
    balance    = 16'd500;
    test_reset();
    test_withdraw();
    test_lockout();
    test_rejected();
    test_timeout();
    test_same_cycle();
    test_reset_mid_dispense();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
